// File: rtl/seg_capture_decoder_if.sv
// Capture-side and decoded-update signals of the seven-segment capture decoder.
// The slave modport is the decoder; the master modport is the display source plus consumer.
interface seg_capture_decoder_if;
  logic [7:0] HEX;
  logic [2:0] DIG;
  logic       STB;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [2:0] OUT_DIG;
  logic [3:0] NUM;
  logic       DEC;
  logic       SIGN;
  logic       OFF;
  logic       ERR;
  logic       OVF;
  logic       dbg_state;

  modport slave (
    input  HEX, DIG, STB, OUT_READY,
    output OUT_VALID, OUT_DIG, NUM, DEC, SIGN, OFF, ERR, OVF, dbg_state
  );

  modport master (
    output HEX, DIG, STB, OUT_READY,
    input  OUT_VALID, OUT_DIG, NUM, DEC, SIGN, OFF, ERR, OVF, dbg_state
  );
endinterface

// File: rtl/seg_capture_decoder.sv
// Filters strobed seven-segment samples for stability, decodes accepted patterns and
// reports per-digit changes through a valid/ready output register.
module seg_capture_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  seg_capture_decoder_if.slave bus
);

  // Handshake: an update is offered while OUT_VALID is high and transfers on a rising
  // edge where OUT_READY is also high; the offered fields never change until then.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam logic [3:0] NDIG   = 4'(NUM_DIGITS);

  state_t      state_q, state_d;
  logic [10:0] cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shadow_q [NUM_DIGITS];
  logic [2:0]  out_dig_q;
  logic [3:0]  num_q;
  logic        dec_q, sign_q, off_q, err_q, ovf_q;

  logic        strobe_ok, accept, changed, load_en, ovf_set;
  logic [10:0] sample;
  logic [7:0]  cur_shadow;
  logic [6:0]  dec_fields;

  // Returns {num[3:0], sign, off, err} for the active-low segment field g..a.
  function automatic logic [6:0] decode7(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {4'h0, 3'b000};
      7'b1111001: return {4'h1, 3'b000};
      7'b0100100: return {4'h2, 3'b000};
      7'b0110000: return {4'h3, 3'b000};
      7'b0011001: return {4'h4, 3'b000};
      7'b0010010: return {4'h5, 3'b000};
      7'b0000010: return {4'h6, 3'b000};
      7'b1111000: return {4'h7, 3'b000};
      7'b0000000: return {4'h8, 3'b000};
      7'b0010000: return {4'h9, 3'b000};
      7'b0001000: return {4'hA, 3'b000};
      7'b0000011: return {4'hB, 3'b000};
      7'b1000110: return {4'hC, 3'b000};
      7'b0100001: return {4'hD, 3'b000};
      7'b0000110: return {4'hE, 3'b000};
      7'b0001110: return {4'hF, 3'b000};
      7'b0111111: return {4'h0, 3'b100};
      7'b1111111: return {4'h0, 3'b010};
      default:    return {4'h0, 3'b001};
    endcase
  endfunction

  always_comb begin
    strobe_ok = bus.STB && ({1'b0, bus.DIG} < NDIG);
    sample    = {bus.DIG, bus.HEX};
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    if (strobe_ok) begin
      if (sample == cand_q) begin
        if (cnt_q != STABLE) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = sample;
        cnt_d  = 4'd1;
      end
    end
  end

  // A fresh candidate reaching the threshold also counts, which matters when STABLE_CYCLES is 1.
  assign accept = strobe_ok && (cnt_d == STABLE) && ((sample != cand_q) || (cnt_q != STABLE));

  always_comb begin
    cur_shadow = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.DIG == 3'(i)) cur_shadow = shadow_q[i];
    end
  end

  assign changed    = accept && (bus.HEX != cur_shadow);
  assign dec_fields = decode7(bus.HEX[6:0]);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (changed) state_d = HOLD;
      HOLD:    if (bus.OUT_READY && !changed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: load_en = changed;
      HOLD: begin
        load_en = changed && bus.OUT_READY;
        ovf_set = changed && !bus.OUT_READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cand_q    <= {3'd0, 8'hFF};
      cnt_q     <= 4'd0;
      out_dig_q <= 3'd0;
      num_q     <= 4'd0;
      dec_q     <= 1'b0;
      sign_q    <= 1'b0;
      off_q     <= 1'b1;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= 8'hFF;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      if (load_en) begin
        out_dig_q <= bus.DIG;
        num_q     <= dec_fields[6:3];
        dec_q     <= ~bus.HEX[7];
        sign_q    <= dec_fields[2];
        off_q     <= dec_fields[1];
        err_q     <= dec_fields[0];
      end
      if (ovf_set) ovf_q <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load_en && (bus.DIG == 3'(i))) shadow_q[i] <= bus.HEX;
      end
    end
  end

  assign bus.OUT_VALID = (state_q == HOLD);
  assign bus.OUT_DIG   = out_dig_q;
  assign bus.NUM       = num_q;
  assign bus.DEC       = dec_q;
  assign bus.SIGN      = sign_q;
  assign bus.OFF       = off_q;
  assign bus.ERR       = err_q;
  assign bus.OVF       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed scenarios plus randomized strobe traffic against a behavioural model of the
// stability filter, per-digit shadows and single-slot output register.
module tb_seg_capture_decoder;
  localparam int ND = 6;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_capture_decoder_if bus();

  seg_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [2:0]  m_cdig;
  logic [7:0]  m_chex;
  int          m_cnt;
  logic [7:0]  m_shadow [8];
  logic        m_valid, m_dec, m_sign, m_off, m_err, m_ovf;
  logic [2:0]  m_dig;
  logic [3:0]  m_num;
  logic [10:0] exp_q [$];

  function automatic logic [6:0] ref_decode(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (s == seg_tab[v]) return {4'(v), 3'b000};
    if (s == 7'h3F) return 7'b0000100;
    if (s == 7'h7F) return 7'b0000010;
    return 7'b0000001;
  endfunction

  task automatic model_reset();
    m_cdig = 3'd0; m_chex = 8'hFF; m_cnt = 0;
    for (int i = 0; i < 8; i++) m_shadow[i] = 8'hFF;
    m_valid = 0; m_dig = 0; m_num = 0; m_dec = 0; m_sign = 0; m_off = 1; m_err = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [7:0] hex, input logic [2:0] dig,
                            input logic stb, input logic ready, input logic r);
    logic acc, chg;
    logic [6:0] d;
    if (r) begin model_reset(); return; end
    acc = 0;
    if (stb && int'(dig) < ND) begin
      if (dig == m_cdig && hex == m_chex) begin
        if (m_cnt < SC) begin m_cnt++; acc = (m_cnt == SC); end
      end else begin
        m_cdig = dig; m_chex = hex; m_cnt = 1; acc = (SC == 1);
      end
    end
    chg = acc && (hex != m_shadow[dig]);
    if (m_valid && !ready) begin
      if (chg) m_ovf = 1;
    end else if (chg) begin
      d = ref_decode(hex[6:0]);
      m_dig = dig; m_num = d[6:3]; m_dec = ~hex[7];
      m_sign = d[2]; m_off = d[1]; m_err = d[0];
      m_valid = 1; m_shadow[dig] = hex;
      exp_q.push_back({m_dig, m_num, m_dec, m_sign, m_off, m_err});
    end else if (m_valid) begin
      m_valid = 0;
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic cyc(input logic [7:0] hex, input logic [2:0] dig, input logic stb,
                     input logic ready, input logic r = 1'b0);
    logic [10:0] e;
    bus.HEX = hex; bus.DIG = dig; bus.STB = stb; bus.OUT_READY = ready; rst = r;
    #1;
    if (bus.OUT_VALID && ready && !r) begin
      if (exp_q.size() == 0) check("sb_unexpected_xfer", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_xfer", {bus.OUT_DIG, bus.NUM, bus.DEC, bus.SIGN, bus.OFF, bus.ERR}, e);
      end
    end
    @(posedge clk);
    model_edge(hex, dig, stb, ready, r);
    #1;
    check("out_valid", bus.OUT_VALID, m_valid);
    check("state",     bus.dbg_state, m_valid);
    check("out_dig",   bus.OUT_DIG,   m_dig);
    check("num",       bus.NUM,       m_num);
    check("dec",       bus.DEC,       m_dec);
    check("sign",      bus.SIGN,      m_sign);
    check("off",       bus.OFF,       m_off);
    check("err",       bus.ERR,       m_err);
    check("ovf",       bus.OVF,       m_ovf);
  endtask

  task automatic present(input logic [7:0] hex, input logic [2:0] dig, input int n, input logic ready);
    for (int i = 0; i < n; i++) cyc(hex, dig, 1'b1, ready);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r_hex;
    logic [2:0] r_dig;
    int sel;
    model_reset();
    bus.HEX = 8'hFF; bus.DIG = 0; bus.STB = 0; bus.OUT_READY = 0; rst = 1;
    cyc(8'hFF, 0, 0, 0, 1);
    cyc(8'hFF, 0, 0, 0, 1);
    check("rst_valid", bus.OUT_VALID, 0);
    check("rst_off",   bus.OFF, 1);
    check("rst_ovf",   bus.OVF, 0);

    // blank display after reset: no update
    present(8'hFF, 0, 5, 1);
    present(8'hFF, 3, 5, 1);

    // digit 2 shows 3, then the same pattern keeps coming
    present(8'hB0, 2, 3, 1);
    check("s32_valid", bus.OUT_VALID, 1);
    check("s32_dig",   bus.OUT_DIG, 2);
    check("s32_num",   bus.NUM, 3);
    present(8'hB0, 2, 10, 1);
    check("s32_idle",  bus.OUT_VALID, 0);

    // alternating patterns never settle; then 0 with the point lit
    for (int i = 0; i < 8; i++) cyc((i % 2 == 0) ? 8'hC0 : 8'hF9, 0, 1, 1);
    check("s33_none", bus.OUT_VALID, 0);
    present(8'h40, 0, 3, 1);
    check("s33_num", bus.NUM, 0);
    check("s33_dec", bus.DEC, 1);

    // minus sign, unknown pattern, out-of-range digits
    present(8'hBF, 1, 3, 1);
    check("s34_sign", bus.SIGN, 1);
    present(8'hF7, 1, 3, 1);
    check("s34_err", bus.ERR, 1);
    present(8'h99, 6, 4, 1);
    present(8'h82, 7, 4, 1);
    check("s34_oor", bus.OUT_VALID, 0);

    // consumer stalled: second change dropped, overflow flagged
    present(8'hA4, 0, 3, 0);
    present(8'h99, 1, 3, 0);
    check("s35_hold_num", bus.NUM, 2);
    check("s35_ovf", bus.OVF, 1);
    cyc(8'h99, 1, 0, 1);
    cyc(8'h99, 1, 0, 1);
    check("s35_drained", bus.OUT_VALID, 0);

    // back-to-back updates with the second accept on the transfer edge
    cyc(8'hFF, 0, 0, 0, 1);
    present(8'h92, 3, 3, 0);
    present(8'h82, 4, 2, 0);
    cyc(8'h82, 4, 1, 1);
    check("s36_b2b_valid", bus.OUT_VALID, 1);
    check("s36_b2b_dig", bus.OUT_DIG, 4);
    cyc(8'h82, 4, 0, 1);
    check("s36_ovf", bus.OVF, 0);

    // reset mid-transfer, then the same pattern is reported again
    present(8'hF8, 5, 3, 0);
    cyc(8'hF8, 5, 0, 0, 1);
    check("s37_valid", bus.OUT_VALID, 0);
    check("s37_off", bus.OFF, 1);
    present(8'hF8, 5, 3, 0);
    check("s37_again", bus.NUM, 7);
    cyc(8'hF8, 5, 0, 1);

    // randomized traffic
    r_hex = 8'hFF; r_dig = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 19);
        if (sel < 16)       r_hex = {1'($urandom_range(0, 1)), seg_tab[sel]};
        else if (sel == 16) r_hex = 8'hBF;
        else if (sel == 17) r_hex = 8'hFF;
        else                r_hex = 8'($urandom);
        r_dig = 3'($urandom_range(0, 7));
      end
      cyc(r_hex, r_dig, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 299) == 0));
    end

    check("sb_residue", exp_q.size(), m_valid ? 1 : 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
